// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo processor: state encoding, audio limits,
// saturation and the BCD / 7-segment helpers used by the optional delay display.
package echo_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_CALC  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  localparam logic [9:0]         MIDSCALE = 10'h200;
  localparam logic signed [10:0] SAT_MAX  = 11'sd511;
  localparam logic signed [10:0] SAT_MIN  = -11'sd512;

  function automatic logic [9:0] saturate(input logic signed [10:0] v);
    if (v > SAT_MAX) begin
      saturate = 10'h1FF;
    end else if (v < SAT_MIN) begin
      saturate = 10'h200;
    end else begin
      saturate = v[9:0];
    end
  endfunction

  // Double-dabble correction: every BCD digit of 5 or more gets 3 added before the shift.
  function automatic logic [15:0] bcd_add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = r[i*4 +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Single-port synchronous delay memory holding past output samples; 1-cycle read latency.
module delay_ram #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write-first is irrelevant here: reads and writes never target the same cycle's data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/echo_processor.sv
// Feedback echo stage: y[n] = x[n] + (y[n-D] >>> GAIN_SHIFT), D = SW*DELAY_STEP.
// Optional HEX_DELAY_EN builds a double-dabble converter showing D on HEX3..HEX0.
module echo_processor
  import echo_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DELAY_STEP = 16,
  parameter int GAIN_SHIFT = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       data_valid,
  input  logic [9:0] data_in,
  input  logic [8:0] SW,
  output logic [9:0] data_out,
  output logic       out_valid,
  output logic [6:0] HEX0_D,
  output logic [6:0] HEX1_D,
  output logic [6:0] HEX2_D,
  output logic [6:0] HEX3_D
);

  state_e                   state_r, state_s;
  logic [ADDR_W-1:0]        wr_ptr_r, clr_addr_r, rd_addr_r;
  logic [ADDR_W-1:0]        d_s, ram_addr_s;
  logic                     ram_we_s, d_zero_r;
  logic [9:0]               ram_wdata_s, ram_rdata_s, e_s, y_r;
  logic signed [9:0]        x_r;
  logic signed [10:0]       e_ext_s, sum_s;

  assign d_s = ADDR_W'(SW * DELAY_STEP);

  delay_ram #(.ADDR_W(ADDR_W), .DATA_W(10)) u_ram (
    .clk   (CLOCK_50),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Echo arithmetic at 11-bit signed width; D==0 ignores whatever the RAM returned.
  assign e_s     = d_zero_r ? 10'h000 : ram_rdata_s;
  assign e_ext_s = $signed({e_s[9], e_s}) >>> GAIN_SHIFT;
  assign sum_s   = $signed({x_r[9], x_r}) + e_ext_s;

  // Next-state and RAM port steering.
  always_comb begin
    state_s     = state_r;
    ram_we_s    = 1'b0;
    ram_addr_s  = rd_addr_r;
    ram_wdata_s = 10'h000;
    case (state_r)
      ST_CLEAR: begin
        ram_we_s   = 1'b1;
        ram_addr_s = clr_addr_r;
        if (clr_addr_r == {ADDR_W{1'b1}}) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        ram_addr_s = wr_ptr_r - d_s;
        if (data_valid) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ:  state_s = ST_CALC;
      ST_CALC:  state_s = ST_WRITE;
      ST_WRITE: begin
        ram_we_s    = 1'b1;
        ram_addr_s  = wr_ptr_r;
        ram_wdata_s = y_r;
        state_s     = ST_IDLE;
      end
      default:  state_s = ST_CLEAR;
    endcase
  end

  // State register and sample datapath.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      wr_ptr_r   <= {ADDR_W{1'b0}};
      clr_addr_r <= {ADDR_W{1'b0}};
      rd_addr_r  <= {ADDR_W{1'b0}};
      x_r        <= 10'sd0;
      d_zero_r   <= 1'b0;
      y_r        <= 10'h000;
      data_out   <= MIDSCALE;
      out_valid  <= 1'b0;
    end else begin
      state_r   <= state_s;
      out_valid <= 1'b0;
      case (state_r)
        ST_CLEAR: clr_addr_r <= clr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        ST_IDLE: begin
          if (data_valid) begin
            x_r       <= $signed(data_in ^ MIDSCALE);
            d_zero_r  <= (d_s == {ADDR_W{1'b0}});
            rd_addr_r <= ram_addr_s;
          end
        end
        ST_CALC:  y_r <= saturate(sum_s);
        ST_WRITE: begin
          data_out  <= y_r ^ MIDSCALE;
          out_valid <= 1'b1;
          wr_ptr_r  <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

`ifdef HEX_DELAY_EN
  logic [8:0]  sw_seen_r;
  logic [12:0] bin_r;
  logic [15:0] bcd_r;
  logic [3:0]  cnt_r;
  logic        busy_r, first_r;

  // Restart conversion on any SW change, so the display settles ~15 cycles after the last one.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      HEX0_D    <= 7'h7F;
      HEX1_D    <= 7'h7F;
      HEX2_D    <= 7'h7F;
      HEX3_D    <= 7'h7F;
      sw_seen_r <= 9'h000;
      bin_r     <= 13'h0000;
      bcd_r     <= 16'h0000;
      cnt_r     <= 4'd0;
      busy_r    <= 1'b0;
      first_r   <= 1'b1;
    end else if (first_r || (SW != sw_seen_r)) begin
      sw_seen_r <= SW;
      bin_r     <= d_s;
      bcd_r     <= 16'h0000;
      cnt_r     <= 4'd13;
      busy_r    <= 1'b1;
      first_r   <= 1'b0;
    end else if (busy_r) begin
      if (cnt_r != 4'd0) begin
        {bcd_r, bin_r} <= {bcd_add3(bcd_r), bin_r} << 1;
        cnt_r          <= cnt_r - 4'd1;
      end else begin
        HEX0_D <= seg7(bcd_r[3:0]);
        HEX1_D <= seg7(bcd_r[7:4]);
        HEX2_D <= seg7(bcd_r[11:8]);
        HEX3_D <= seg7(bcd_r[15:12]);
        busy_r <= 1'b0;
      end
    end
  end
`else
  assign HEX0_D = 7'h7F;
  assign HEX1_D = 7'h7F;
  assign HEX2_D = 7'h7F;
  assign HEX3_D = 7'h7F;
`endif

endmodule

// File: tb/tb_echo_processor.sv
// Directed self-checking bench for echo_processor (default build or HEX_DELAY_EN).
module tb_echo_processor;

  logic       clk = 1'b0;
  logic       reset, data_valid;
  logic [9:0] data_in;
  logic [8:0] SW;
  logic [9:0] data_out;
  logic       out_valid;
  logic [6:0] hex0, hex1, hex2, hex3;
  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  echo_processor dut (
    .CLOCK_50(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in), .SW(SW),
    .data_out(data_out), .out_valid(out_valid),
    .HEX0_D(hex0), .HEX1_D(hex1), .HEX2_D(hex2), .HEX3_D(hex3)
  );

  task automatic send_sample(input logic [9:0] din, output logic [9:0] dout,
                             output logic early, output logic on_time);
    @(negedge clk); data_in = din; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0; early = out_valid;
    @(negedge clk); early = early | out_valid;
    @(negedge clk); early = early | out_valid;
    @(negedge clk); on_time = out_valid; dout = data_out;
  endtask

  task automatic restart_and_clear();
    @(negedge clk); reset = 1'b1; data_valid = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    repeat (8200) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; data_valid = 1'b0; data_in = 10'd0; SW = 9'd0;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 10'h200) begin failures++; $display("FAIL reset_data_out got=%h exp=200", data_out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({hex3, hex2, hex1, hex0} !== {4{7'h7F}}) begin failures++;
      $display("FAIL reset_hex got=%h %h %h %h exp=7f", hex3, hex2, hex1, hex0); end
  endtask

  task automatic test_clear_then_pass();
    int first_seen;
    int early_cnt;
    first_seen = -1; early_cnt = 0;
    data_in = 10'd700; SW = 9'd0; data_valid = 1'b1;
    reset = 1'b0;
    for (int i = 1; i <= 8300 && first_seen < 0; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        first_seen = i;
        data_valid = 1'b0;
      end
      if (i <= 8192 && out_valid !== 1'b0) early_cnt++;
    end
    checks++; if (early_cnt != 0) begin failures++; $display("FAIL clear_no_out_valid got=%0d exp=0", early_cnt); end
    checks++; if (first_seen != 8196) begin failures++; $display("FAIL clear_first_out_cycle got=%0d exp=8196", first_seen); end
    checks++; if (data_out !== 10'd700) begin failures++; $display("FAIL passthrough got=%0d exp=700", data_out); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_echo();
    logic [9:0] d;
    logic e, v;
    logic [9:0] exp_v;
    restart_and_clear();
    SW = 9'd1;
    send_sample(10'd1023, d, e, v);
    checks++; if (d !== 10'd1023 || e !== 1'b0 || v !== 1'b1) begin failures++;
      $display("FAIL echo_first got=%0d early=%b valid=%b exp=1023 early=0 valid=1", d, e, v); end
    for (int i = 1; i <= 48; i++) begin
      send_sample(10'd512, d, e, v);
      if (i == 1 || i == 16 || i == 32 || i == 48) begin
        exp_v = (i == 16) ? 10'd767 : (i == 32) ? 10'd639 : (i == 48) ? 10'd575 : 10'd512;
        checks++; if (d !== exp_v || v !== 1'b1) begin failures++;
          $display("FAIL echo_tap_%0d got=%0d valid=%b exp=%0d", i, d, v, exp_v); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [9:0] d;
    logic e, v;
    SW = 9'd1;
    for (int i = 0; i < 20; i++) begin
      send_sample(10'd1023, d, e, v);
      checks++; if (d !== 10'd1023 || v !== 1'b1) begin failures++;
        $display("FAIL sat_high_%0d got=%0d exp=1023", i, d); end
    end
    for (int i = 0; i < 40; i++) begin
      send_sample(10'd0, d, e, v);
      if (i >= 16) begin
        checks++; if (d !== 10'd0 || v !== 1'b1) begin failures++;
          $display("FAIL sat_low_%0d got=%0d exp=0", i, d); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    SW = 9'd0;
    @(negedge clk); data_in = 10'd300; data_valid = 1'b1;
    @(negedge clk); data_in = 10'd900;
    @(negedge clk); data_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    checks++; if (data_out !== 10'd300) begin failures++; $display("FAIL b2b_data got=%0d exp=300", data_out); end
  endtask

  task automatic test_reset_abort();
    logic [9:0] d;
    logic e, v;
    SW = 9'd0;
    @(negedge clk); data_in = 10'd512; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++; if (data_out !== 10'h200 || out_valid !== 1'b0) begin failures++;
      $display("FAIL abort_state got=%h valid=%b exp=200 valid=0", data_out, out_valid); end
    reset = 1'b0;
    repeat (8200) @(negedge clk);
    SW = 9'd511;
    send_sample(10'd512, d, e, v);
    checks++; if (d !== 10'd512 || v !== 1'b1) begin failures++;
      $display("FAIL abort_ram_cleared got=%0d valid=%b exp=512", d, v); end
  endtask

  task automatic test_hex();
    logic [27:0] exp_hex;
    SW = 9'd3;
    repeat (20) @(negedge clk);
    SW = 9'd511;
`ifdef HEX_DELAY_EN
    exp_hex = {7'h00, 7'h79, 7'h78, 7'h02};
`else
    exp_hex = {4{7'h7F}};
`endif
    repeat (20) @(negedge clk);
    checks++; if ({hex3, hex2, hex1, hex0} !== exp_hex) begin failures++;
      $display("FAIL hex_sw511 got=%h exp=%h", {hex3, hex2, hex1, hex0}, exp_hex); end
  endtask

  initial begin
    test_reset();
    test_clear_then_pass();
    test_echo();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    test_hex();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
